// File: rtl/ecc_point_validate.sv
// ecc_point_validate: checks that a candidate base point (Px, Py) lies on
// y^2 = x^3 + a*x + b (mod p) before a Montgomery-ladder scalar multiplier
// consumes it. Four sequential bit-serial modular multiplies are followed
// by one modular sum and one compare. Out-of-range operands are rejected
// one cycle after the request is accepted.
module ecc_point_validate #(
    parameter int integer_size = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [integer_size-1:0] prime,
    input  logic [integer_size-1:0] A,
    input  logic [integer_size-1:0] B,
    input  logic [integer_size-1:0] Px,
    input  logic [integer_size-1:0] Py,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    range_err,
    output logic [integer_size-1:0] Qx,
    output logic [integer_size-1:0] Qy
);

    localparam int W  = integer_size;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RANGE,
        MUL_YY,
        MUL_XX,
        MUL_XXX,
        MUL_AX,
        SUM,
        CMP
    } state_t;

    state_t state, state_next;

    // Operands captured at the accepting edge; later input changes are ignored.
    logic [W-1:0] p_r, a_r, b_r, x_r, y_r;

    // Intermediate products and the curve right-hand side.
    logic [W-1:0] yy_r, xx_r, xxx_r, ax_r, rhs_r;

    // Shift-add multiplier accumulator and bit index (MSB first).
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;

    // Modular add of two values already reduced below m. The sum fits in
    // W+1 bits, and one conditional subtraction brings it back below m.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[W-1:0];
    endfunction

    logic [W-1:0] mul_u;
    logic [W-1:0] mul_v;
    logic [W-1:0] acc_dbl;
    logic [W-1:0] acc_next;
    logic         mul_last;
    logic         range_bad;
    logic [W-1:0] sum_xa;
    logic [W-1:0] sum_rhs;

    // Operand selection and one multiplier step: acc = 2*acc (+u if v bit set) mod p.
    always_comb begin
        mul_u = '0;
        mul_v = '0;
        case (state)
            MUL_YY:  begin mul_u = y_r;  mul_v = y_r; end
            MUL_XX:  begin mul_u = x_r;  mul_v = x_r; end
            MUL_XXX: begin mul_u = xx_r; mul_v = x_r; end
            MUL_AX:  begin mul_u = a_r;  mul_v = x_r; end
            default: begin mul_u = '0;   mul_v = '0;  end
        endcase
        acc_dbl  = mod_add(acc, acc, p_r);
        acc_next = mod_add(acc_dbl, mul_v[cnt] ? mul_u : '0, p_r);
        mul_last = (cnt == '0);
        range_bad = (p_r < W'(3)) || !p_r[0] ||
                    (a_r >= p_r) || (b_r >= p_r) ||
                    (x_r >= p_r) || (y_r >= p_r);
        sum_xa  = mod_add(xxx_r, ax_r, p_r);
        sum_rhs = mod_add(sum_xa, b_r, p_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; each multiply state holds for W cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = RANGE;
            RANGE:   state_next = range_bad ? IDLE : MUL_YY;
            MUL_YY:  if (mul_last) state_next = MUL_XX;
            MUL_XX:  if (mul_last) state_next = MUL_XXX;
            MUL_XXX: if (mul_last) state_next = MUL_AX;
            MUL_AX:  if (mul_last) state_next = SUM;
            SUM:     state_next = CMP;
            CMP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, multiplier datapath and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_r       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            yy_r      <= '0;
            xx_r      <= '0;
            xxx_r     <= '0;
            ax_r      <= '0;
            rhs_r     <= '0;
            acc       <= '0;
            cnt       <= CNT_TOP;
            Qx        <= '0;
            Qy        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            range_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        p_r       <= prime;
                        a_r       <= A;
                        b_r       <= B;
                        x_r       <= Px;
                        y_r       <= Py;
                        Qx        <= Px;
                        Qy        <= Py;
                        acc       <= '0;
                        cnt       <= CNT_TOP;
                        valid     <= 1'b0;
                        range_err <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RANGE: begin
                    if (range_bad) begin
                        range_err <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                MUL_YY, MUL_XX, MUL_XXX, MUL_AX: begin
                    if (mul_last) begin
                        acc <= '0;
                        cnt <= CNT_TOP;
                        case (state)
                            MUL_YY:  yy_r  <= acc_next;
                            MUL_XX:  xx_r  <= acc_next;
                            MUL_XXX: xxx_r <= acc_next;
                            default: ax_r  <= acc_next;
                        endcase
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                SUM: begin
                    rhs_r <= sum_rhs;
                end
                CMP: begin
                    valid <= (yy_r == rhs_r);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_point_validate.sv
// Directed bench for ecc_point_validate with hand-computed curve results.
module tb_ecc_point_validate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic [63:0] prime = '0, A = '0, B = '0, Px = '0, Py = '0;
    logic        busy, done, valid, range_err;
    logic [63:0] Qx, Qy;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] BIGP = 64'hFFFF_FFFF_FFFF_FFC5; // 2^64 - 59

    ecc_point_validate #(.integer_size(64)) dut (
        .clk(clk), .rst(rst), .go(go),
        .prime(prime), .A(A), .B(B), .Px(Px), .Py(Py),
        .busy(busy), .done(done), .valid(valid), .range_err(range_err),
        .Qx(Qx), .Qy(Qy)
    );

    always #5 clk = ~clk;

    // Drive operands and a one-cycle go pulse; returns #1 after edge E0.
    task automatic start_op(input logic [63:0] p, a, b, x, y);
        @(negedge clk);
        prime = p; A = a; B = b; Px = x; Py = y;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    // Count edges after E0 until done is seen; -1 when the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, valid, range_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, done, valid, range_err});
        end
        checks++;
        if (Qx !== 64'd0 || Qy !== 64'd0) begin
            failures++;
            $display("FAIL reset_q got=%0d,%0d exp=0,0", Qx, Qy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_valid_point();
        int lat;
        start_op(64'd11, 64'd2, 64'd3, 64'd2, 64'd9);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_go got=%b exp=1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 259) begin
            failures++;
            $display("FAIL valid_latency got=%0d exp=259", lat);
        end
        checks++;
        if ({valid, range_err, busy} !== 3'b100) begin
            failures++;
            $display("FAIL valid_point_flags got=%b exp=100", {valid, range_err, busy});
        end
        checks++;
        if (Qx !== 64'd2 || Qy !== 64'd9) begin
            failures++;
            $display("FAIL valid_point_q got=%0d,%0d exp=2,9", Qx, Qy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse_hold got=done%b valid%b exp=done0 valid1", done, valid);
        end
    endtask

    task automatic test_invalid_point();
        int lat;
        start_op(64'd11, 64'd2, 64'd3, 64'd2, 64'd7);
        wait_done(lat);
        checks++;
        if (lat != 259) begin
            failures++;
            $display("FAIL invalid_latency got=%0d exp=259", lat);
        end
        checks++;
        if ({valid, range_err} !== 2'b00) begin
            failures++;
            $display("FAIL invalid_point_flags got=%b exp=00", {valid, range_err});
        end
    endtask

    task automatic test_range();
        int lat;
        start_op(64'd11, 64'd2, 64'd3, 64'd0, 64'd5);
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b1 || range_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_x_point got=lat%0d valid%b err%b exp=lat259 valid1 err0", lat, valid, range_err);
        end
        start_op(64'd11, 64'd2, 64'd3, 64'd11, 64'd5);
        wait_done(lat);
        checks++;
        if (lat != 1 || {valid, range_err, busy} !== 3'b010) begin
            failures++;
            $display("FAIL x_eq_p got=lat%0d flags%b exp=lat1 flags010", lat, {valid, range_err, busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || range_err !== 1'b1) begin
            failures++;
            $display("FAIL err_hold got=done%b err%b exp=done0 err1", done, range_err);
        end
        start_op(64'd10, 64'd2, 64'd3, 64'd2, 64'd9);
        wait_done(lat);
        checks++;
        if (lat != 1 || range_err !== 1'b1) begin
            failures++;
            $display("FAIL even_p got=lat%0d err%b exp=lat1 err1", lat, range_err);
        end
        start_op(64'd1, 64'd0, 64'd0, 64'd0, 64'd0);
        wait_done(lat);
        checks++;
        if (lat != 1 || range_err !== 1'b1) begin
            failures++;
            $display("FAIL small_p got=lat%0d err%b exp=lat1 err1", lat, range_err);
        end
        start_op(64'd11, 64'd11, 64'd3, 64'd2, 64'd9);
        wait_done(lat);
        checks++;
        if (lat != 1 || range_err !== 1'b1) begin
            failures++;
            $display("FAIL a_eq_p got=lat%0d err%b exp=lat1 err1", lat, range_err);
        end
    endtask

    task automatic test_go_ignored();
        int dones = 0;
        int first = -1;
        start_op(64'd11, 64'd2, 64'd3, 64'd2, 64'd9);
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 99) begin
                go = 1'b1;
                Px = 64'd2;
                Py = 64'd7;
            end
            if (n == 100) go = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (dones != 1 || first != 259) begin
            failures++;
            $display("FAIL go_while_busy got=dones%0d at%0d exp=dones1 at259", dones, first);
        end
        checks++;
        if (valid !== 1'b1 || Qy !== 64'd9) begin
            failures++;
            $display("FAIL go_while_busy_result got=valid%b qy%0d exp=valid1 qy9", valid, Qy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        prime = 64'd11; A = 64'd2; B = 64'd3; Px = 64'd0; Py = 64'd5;
        go = 1'b1;
        @(posedge clk);
        #1;
        Px = 64'd2;
        Py = 64'd7;
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b1 || Qx !== 64'd0 || Qy !== 64'd5) begin
            failures++;
            $display("FAIL b2b_first got=lat%0d valid%b q%0d,%0d exp=lat259 valid1 q0,5", lat, valid, Qx, Qy);
        end
        @(posedge clk);
        #1;
        go = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || Qx !== 64'd2 || valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got=busy%b done%b qx%0d valid%b exp=busy1 done0 qx2 valid0", busy, done, Qx, valid);
        end
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b0 || range_err !== 1'b0 || Qy !== 64'd7) begin
            failures++;
            $display("FAIL b2b_second got=lat%0d valid%b err%b qy%0d exp=lat259 valid0 err0 qy7", lat, valid, range_err, Qy);
        end
    endtask

    task automatic test_wide();
        int lat;
        start_op(BIGP, BIGP - 64'd1, 64'd1, 64'd1, BIGP - 64'd1);
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b1 || range_err !== 1'b0) begin
            failures++;
            $display("FAIL wide_p got=lat%0d valid%b err%b exp=lat259 valid1 err0", lat, valid, range_err);
        end
        start_op(BIGP, BIGP - 64'd1, 64'd2, 64'd1, BIGP - 64'd1);
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b0) begin
            failures++;
            $display("FAIL wide_p_off got=lat%0d valid%b exp=lat259 valid0", lat, valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(64'd11, 64'd2, 64'd3, 64'd2, 64'd9);
        repeat (130) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, range_err} !== 4'b0000 || Qx !== 64'd0 || Qy !== 64'd0) begin
            failures++;
            $display("FAIL async_reset got=flags%b q%0d,%0d exp=flags0000 q0,0", {busy, done, valid, range_err}, Qx, Qy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_op(64'd11, 64'd2, 64'd3, 64'd2, 64'd9);
        wait_done(lat);
        checks++;
        if (lat != 259 || valid !== 1'b1 || Qx !== 64'd2 || Qy !== 64'd9) begin
            failures++;
            $display("FAIL after_reset got=lat%0d valid%b q%0d,%0d exp=lat259 valid1 q2,9", lat, valid, Qx, Qy);
        end
    endtask

    initial begin
        test_reset();
        test_valid_point();
        test_invalid_point();
        test_range();
        test_go_ignored();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_point_validate.md
ECC_POINT_VALIDATE -- requirements
Module: ecc_point_validate

Interface
REQ-001 Parameter: integer_size, default 64, width of prime, curve coefficients and point coordinates.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; one clock; rst=0 resets immediately, release is synchronous to clk.
REQ-004 go  input  1  start request; sampled only in IDLE.
REQ-005 prime  input  integer_size  field modulus p.
REQ-006 A  input  integer_size  curve coefficient a, curve y^2 = x^3 + a*x + b mod p.
REQ-007 B  input  integer_size  curve coefficient b.
REQ-008 Px, Py  input  integer_size each  candidate base point for the downstream Montgomery-ladder scalar multiplier.
REQ-009 busy  output  1  high from the go-accept edge until done is asserted.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 valid  output  1  point lies on curve and all range checks passed; held until next accepted go.
REQ-012 range_err  output  1  operand or modulus illegal; held until next accepted go.
REQ-013 Qx, Qy  output  integer_size each  registered copy of Px/Py captured at go; ladder consumes these only when valid=1.

Function
REQ-014 States: IDLE, RANGE, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, SUM, CMP; any other encoding returns to IDLE.
REQ-015 IDLE with go=1 at edge E0: capture prime, A, B, Px, Py into internal registers and Qx/Qy; clear valid, range_err; set busy; go to RANGE.
REQ-016 Inputs changing after E0 have no effect on the current operation.
REQ-017 RANGE at E1: range_err when p < 3, p even, or any of A, B, Px, Py >= p; on error assert done at E1, clear busy, go IDLE.
REQ-018 RANGE pass at E1: go to MUL_YY.
REQ-019 Modular multiply r = u*v mod p: MSB-first shift-add over integer_size bits, one bit per cycle: acc = 2*acc mod p, then acc = acc + u mod p if v bit set; intermediates integer_size+1 bits, no overflow.
REQ-020 Each MUL state lasts exactly integer_size cycles: MUL_YY = Py*Py, MUL_XX = Px*Px, MUL_XXX = (x^2)*Px, MUL_AX = A*Px.
REQ-021 SUM (one cycle): rhs = ((x^3 + a*x) mod p + b) mod p using conditional subtraction.
REQ-022 CMP (one cycle): valid = (y^2 == rhs); done=1 same edge; busy cleared; go IDLE.
REQ-023 Latency for integer_size=64: pass path done at E259 (1 + 4*64 + 2 cycles after E0); range-error path done at E1.
REQ-024 go while busy is ignored; no queuing.
REQ-025 go held high continuously: a new operation starts on the first IDLE cycle after done.
REQ-026 done never high for more than one consecutive cycle; valid and range_err never both high.
REQ-027 Point at infinity not representable; (0,0) is tested as an ordinary point.

Reset
REQ-028 rst=0 at any time, including mid-multiply: state=IDLE, busy=0, done=0, valid=0, range_err=0, Qx=0, Qy=0, all accumulators 0, immediately and independent of clk.
REQ-029 First go accepted no earlier than the first rising edge after rst release.

Verification
REQ-030 p=11, A=2, B=3, P=(2,9), go pulse -> done at E259, valid=1, range_err=0, Qx=2, Qy=9.
REQ-031 p=11, A=2, B=3, P=(2,7) -> done at E259, valid=0, range_err=0 (y^2=5, rhs=4).
REQ-032 p=11, A=2, B=3, P=(0,5) -> valid=1; then P=(11,5) -> done at E1, range_err=1, valid=0.
REQ-033 p=10 (even), any point -> done at E1, range_err=1; go pulsed again during a busy run at E100 -> ignored, single done at E259.
REQ-034 rst=0 at E130 of a valid run -> all outputs 0 asynchronously; after release, fresh go with P=(2,9) -> correct valid=1 at E259.
